scope_filter_ctl: RTL and testbench

- Sequencer that reconfigures the scope filter (AA/BB/PP/KK coefficients) safely while streaming.
- On an update request it:
  - gates the filter input stream at a beat boundary,
  - drains the filter pipeline,
  - loads the shadow coefficients atomically,
  - pulses the filter's ctl_rst,
  - discards the first output beats while the filter settles.
- Sits between the acquisition stream and the scope_filter instance, with the register bank on the configuration side.

---
 rtl/scope_filter_ctl.sv | 164 ++++++++++++++++
 tb/tb_scope_filter_ctl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_filter_ctl.sv
// Update sequencer for the scope filter: gates input, drains, loads shadow
// coefficients atomically, resets the filter pipeline and hides settling beats.
module scope_filter_ctl #(
  parameter int DRAIN_CYC    = 8,
  parameter int RST_CYC      = 2,
  parameter int SETTLE_BEATS = 16,
  parameter int CW           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] reg_aa,
  input  logic [24:0] reg_bb,
  input  logic [24:0] reg_pp,
  input  logic [24:0] reg_kk,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        busy,
  output logic [17:0] cfg_aa,
  output logic [24:0] cfg_bb,
  output logic [24:0] cfg_pp,
  output logic [24:0] cfg_kk,
  output logic        ctl_rst,
  input  logic        sti_tvalid,
  output logic        sti_tready,
  output logic        flt_tvalid,
  input  logic        flt_tready,
  input  logic        flo_tvalid,
  output logic        flo_tready,
  output logic        sto_tvalid,
  input  logic        sto_tready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LOAD,
    ST_FLUSH,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_BEATS > 0) ? SETTLE_BEATS - 1 : 0);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0]   cfg_aa_q, cfg_aa_d;
  logic [24:0]   cfg_bb_q, cfg_bb_d;
  logic [24:0]   cfg_pp_q, cfg_pp_d;
  logic [24:0]   cfg_kk_q, cfg_kk_d;
  logic          in_stall;

  // Handshakes follow valid/ready: a beat moves when both are high on a clock
  // edge; an offered valid is never withdrawn before its ready arrives.
  assign in_stall = sti_tvalid & ~flt_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      cfg_aa_q  <= '0;
      cfg_bb_q  <= '0;
      cfg_pp_q  <= '0;
      cfg_kk_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      cfg_aa_q  <= cfg_aa_d;
      cfg_bb_q  <= cfg_bb_d;
      cfg_pp_q  <= cfg_pp_d;
      cfg_kk_q  <= cfg_kk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | upd_req;
    cnt_d      = cnt_q;
    cfg_aa_d   = cfg_aa_q;
    cfg_bb_d   = cfg_bb_q;
    cfg_pp_d   = cfg_pp_q;
    cfg_kk_d   = cfg_kk_q;
    sti_tready = flt_tready;
    flt_tvalid = sti_tvalid;
    flo_tready = sto_tready;
    sto_tvalid = flo_tvalid;
    ctl_rst    = 1'b0;
    upd_ack    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A request arriving on the entry cycle stays pending for the next run.
        if (pending_q && !in_stall) begin
          state_d   = ST_DRAIN;
          pending_d = upd_req;
          cnt_d     = '0;
        end
      end
      ST_DRAIN: begin
        sti_tready = 1'b0;
        flt_tvalid = 1'b0;
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOAD: begin
        sti_tready = 1'b0;
        flt_tvalid = 1'b0;
        cfg_aa_d   = reg_aa;
        cfg_bb_d   = reg_bb;
        cfg_pp_d   = reg_pp;
        cfg_kk_d   = reg_kk;
        state_d    = ST_FLUSH;
        cnt_d      = '0;
      end
      ST_FLUSH: begin
        sti_tready = 1'b0;
        flt_tvalid = 1'b0;
        flo_tready = 1'b1;
        sto_tvalid = 1'b0;
        ctl_rst    = 1'b1;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_BEATS == 0) ? ST_DONE : ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        flo_tready = 1'b1;
        sto_tvalid = 1'b0;
        if (flo_tvalid) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        upd_ack = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = pending_q | (state_q != ST_IDLE);
  assign cfg_aa = cfg_aa_q;
  assign cfg_bb = cfg_bb_q;
  assign cfg_pp = cfg_pp_q;
  assign cfg_kk = cfg_kk_q;

endmodule

// File: tb/tb_scope_filter_ctl.sv
// Directed bench for scope_filter_ctl: one instance without settle beats, one
// with 16, sharing clock and reset.
module tb_scope_filter_ctl;

  localparam int DRAIN_CYC = 8;
  localparam int RST_CYC   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---- instance u0: SETTLE_BEATS = 0
  logic [17:0] reg_aa;
  logic [24:0] reg_bb, reg_pp, reg_kk;
  logic        upd_req, upd_ack, busy, ctl_rst;
  logic [17:0] cfg_aa;
  logic [24:0] cfg_bb, cfg_pp, cfg_kk;
  logic        sti_tvalid, sti_tready, flt_tvalid, flt_tready;
  logic        flo_tvalid, flo_tready, sto_tvalid, sto_tready;
  logic [92:0] cfg0_v;
  assign cfg0_v = {cfg_aa, cfg_bb, cfg_pp, cfg_kk};

  scope_filter_ctl #(.DRAIN_CYC(DRAIN_CYC), .RST_CYC(RST_CYC), .SETTLE_BEATS(0), .CW(8)) u0 (
    .clk(clk), .rst(rst),
    .reg_aa(reg_aa), .reg_bb(reg_bb), .reg_pp(reg_pp), .reg_kk(reg_kk),
    .upd_req(upd_req), .upd_ack(upd_ack), .busy(busy),
    .cfg_aa(cfg_aa), .cfg_bb(cfg_bb), .cfg_pp(cfg_pp), .cfg_kk(cfg_kk),
    .ctl_rst(ctl_rst),
    .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .flt_tvalid(flt_tvalid), .flt_tready(flt_tready),
    .flo_tvalid(flo_tvalid), .flo_tready(flo_tready),
    .sto_tvalid(sto_tvalid), .sto_tready(sto_tready)
  );

  // ---- instance u16: SETTLE_BEATS = 16, filter output modelled as silent under ctl_rst
  logic [17:0] s_reg_aa;
  logic [24:0] s_reg_bb, s_reg_pp, s_reg_kk;
  logic        s_upd_req, s_upd_ack, s_busy, s_ctl_rst;
  logic [17:0] s_cfg_aa;
  logic [24:0] s_cfg_bb, s_cfg_pp, s_cfg_kk;
  logic        s_sti_tvalid, s_sti_tready, s_flt_tvalid, s_flt_tready;
  logic        s_flo_tvalid, s_flo_tready, s_sto_tvalid, s_sto_tready, s_flo_en;
  logic [92:0] cfg16_v;
  assign cfg16_v      = {s_cfg_aa, s_cfg_bb, s_cfg_pp, s_cfg_kk};
  assign s_flo_tvalid = s_flo_en & ~s_ctl_rst;

  scope_filter_ctl #(.DRAIN_CYC(DRAIN_CYC), .RST_CYC(RST_CYC), .SETTLE_BEATS(16), .CW(8)) u16 (
    .clk(clk), .rst(rst),
    .reg_aa(s_reg_aa), .reg_bb(s_reg_bb), .reg_pp(s_reg_pp), .reg_kk(s_reg_kk),
    .upd_req(s_upd_req), .upd_ack(s_upd_ack), .busy(s_busy),
    .cfg_aa(s_cfg_aa), .cfg_bb(s_cfg_bb), .cfg_pp(s_cfg_pp), .cfg_kk(s_cfg_kk),
    .ctl_rst(s_ctl_rst),
    .sti_tvalid(s_sti_tvalid), .sti_tready(s_sti_tready),
    .flt_tvalid(s_flt_tvalid), .flt_tready(s_flt_tready),
    .flo_tvalid(s_flo_tvalid), .flo_tready(s_flo_tready),
    .sto_tvalid(s_sto_tvalid), .sto_tready(s_sto_tready)
  );

  // ---- scoreboard and counters
  logic [92:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int acks0    = 0;

  always @(negedge clk) if (upd_ack === 1'b1) acks0++;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [92:0] obs, input logic [92:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [92:0] v);
    {reg_aa, reg_bb, reg_pp, reg_kk} = v;
  endtask

  // Waits (bounded) for an ack on u0 and compares the loaded set against the queue head.
  task automatic wait_ack0(input string tag, input int max_cyc);
    int n;
    bit seen;
    logic [92:0] e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(posedge clk);
      #3;
      n++;
      if (upd_ack === 1'b1) seen = 1'b1;
    end
    chk1({tag, "_ack_seen"}, seen, 1'b1);
    if (seen) begin
      chk1({tag, "_queue_nonempty"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chkv({tag, "_cfg"}, cfg0_v, e);
      end
    end
  endtask

  logic [92:0] set_a, set_b, set_c, set_d, set_e, set_f, set_s;
  int a0, a1, dropped, rst_hi, n;
  bit ack16;
  logic sto_at_ack;

  initial begin
    set_a = {18'h07D93, 25'h00437C7, 25'h0002666, 25'h0D9999A};
    set_b = {18'h3FFFF, 25'h1000000, 25'h0FFFFFF, 25'h0000001};
    set_c = {18'h12345, 25'h0ABCDEF, 25'h1234567, 25'h0F0F0F0};
    set_d = {18'h2AAAA, 25'h1555555, 25'h0AAAAAA, 25'h1FFFFFF};
    set_e = {18'h00101, 25'h0020202, 25'h0030303, 25'h0040404};
    set_f = {18'h1C0DE, 25'h0BEEF01, 25'h1CAFE02, 25'h0FACE03};
    set_s = {18'h0F00F, 25'h0777777, 25'h1333333, 25'h0055555};

    rst = 1'b1;
    set_regs('0);
    upd_req = 1'b0; sti_tvalid = 1'b0; flt_tready = 1'b0; flo_tvalid = 1'b0; sto_tready = 1'b0;
    {s_reg_aa, s_reg_bb, s_reg_pp, s_reg_kk} = set_s;
    s_upd_req = 1'b0; s_sti_tvalid = 1'b0; s_flt_tready = 1'b0; s_flo_en = 1'b0; s_sto_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chkv("rst_cfg0", cfg0_v, '0);
    chk1("rst_busy0", busy, 1'b0);
    chk1("rst_ctl_rst0", ctl_rst, 1'b0);
    chk1("rst_ack0", upd_ack, 1'b0);
    chkv("rst_cfg16", cfg16_v, '0);
    chk1("rst_busy16", s_busy, 1'b0);
    cyc();
    rst = 1'b0;

    // Pass-through with no request
    for (int i = 0; i < 10; i++) begin
      cyc();
      sti_tvalid = 1'b1; flt_tready = 1'b1; sto_tready = 1'b1;
      flo_tvalid = 1'($urandom_range(0, 1));
      #2;
      chk1($sformatf("pt_flt_tvalid_%0d", i), flt_tvalid, 1'b1);
      chk1($sformatf("pt_sti_tready_%0d", i), sti_tready, 1'b1);
      chk1($sformatf("pt_sto_tvalid_%0d", i), sto_tvalid, flo_tvalid);
      chk1($sformatf("pt_flo_tready_%0d", i), flo_tready, 1'b1);
      chk1($sformatf("pt_busy_%0d", i), busy, 1'b0);
    end

    // Latency: req in cycle 0, LOAD in cycle 10, ctl_rst in 11-12, ack in 13
    cyc();
    flo_tvalid = 1'b1; sto_tready = 1'b0;
    set_regs(set_a);
    exp_q.push_back(set_a);
    upd_req = 1'b1;
    #2;
    chk1("lat_busy_c0", busy, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      upd_req = 1'b0;
      if (c == 12) reg_aa = 18'h1234;
      #2;
      chkv($sformatf("lat_cfg_c%0d", c), cfg0_v, (c >= 11) ? set_a : 93'd0);
      chk1($sformatf("lat_ctl_rst_c%0d", c), ctl_rst, (c == 11 || c == 12));
      chk1($sformatf("lat_ack_c%0d", c), upd_ack, c == 13);
      chk1($sformatf("lat_flt_tvalid_c%0d", c), flt_tvalid, !(c >= 2 && c <= 12));
      chk1($sformatf("lat_sti_tready_c%0d", c), sti_tready, !(c >= 2 && c <= 12));
      chk1($sformatf("lat_flo_tready_c%0d", c), flo_tready, (c == 11 || c == 12));
      chk1($sformatf("lat_busy_c%0d", c), busy, c <= 13);
      if (upd_ack === 1'b1 && exp_q.size() > 0) chkv("lat_sb_cfg", cfg0_v, exp_q.pop_front());
    end

    // Stalled input beat when the request arrives
    cyc();
    flt_tready = 1'b0;
    set_regs(set_b);
    exp_q.push_back(set_b);
    upd_req = 1'b1;
    #2;
    chk1("stall_flt_tvalid_c0", flt_tvalid, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      upd_req = 1'b0;
      flt_tready = (c >= 5);
      #2;
      chk1($sformatf("stall_flt_tvalid_c%0d", c), flt_tvalid, c <= 5);
      chk1($sformatf("stall_busy_c%0d", c), busy, 1'b1);
    end
    wait_ack0("stall", 30);

    // Three requests during DRAIN merge into exactly one follow-up update
    cyc();
    a0 = acks0;
    set_regs(set_c);
    exp_q.push_back(set_c);
    upd_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      upd_req = (c == 3 || c == 5 || c == 7);
    end
    upd_req = 1'b0;
    wait_ack0("merge1", 20);
    set_regs(set_d);
    exp_q.push_back(set_d);
    wait_ack0("merge2", 30);
    repeat (30) cyc();
    #2;
    chki("merge_ack_count", acks0 - a0, 2);
    chk1("merge_busy_after", busy, 1'b0);

    // Settle-beat suppression on u16
    cyc();
    s_sti_tvalid = 1'b1; s_flt_tready = 1'b1; s_sto_tready = 1'b1; s_flo_en = 1'b1;
    s_upd_req = 1'b1;
    dropped = 0; rst_hi = 0; ack16 = 1'b0; sto_at_ack = 1'b0; n = 0;
    while (!ack16 && n < 80) begin
      cyc();
      s_upd_req = 1'b0;
      #2;
      n++;
      if (s_ctl_rst === 1'b1) rst_hi++;
      if (s_upd_ack === 1'b1) begin
        ack16 = 1'b1;
        sto_at_ack = s_sto_tvalid;
      end else if (s_flo_tvalid && s_flo_tready && !s_sto_tvalid) begin
        dropped++;
      end
    end
    chk1("settle_ack_seen", ack16, 1'b1);
    chki("settle_dropped", dropped, 16);
    chki("settle_ctl_rst_cycles", rst_hi, RST_CYC);
    chk1("settle_17th_beat_out", sto_at_ack, 1'b1);
    chkv("settle_cfg", cfg16_v, set_s);

    // Reset during FLUSH abandons the sequence without an ack
    cyc();
    set_regs(set_e);
    upd_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      upd_req = 1'b0;
      #2;
    end
    chk1("flush_ctl_rst_before", ctl_rst, 1'b1);
    chkv("flush_cfg_before", cfg0_v, set_e);
    a1 = acks0;
    #1;
    rst = 1'b1;
    #1;
    chk1("arst_ctl_rst", ctl_rst, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chkv("arst_cfg", cfg0_v, '0);
    chk1("arst_ack", upd_ack, 1'b0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (20) cyc();
    #2;
    chki("arst_no_ack", acks0 - a1, 0);
    chk1("arst_idle_busy", busy, 1'b0);
    cyc();
    set_regs(set_f);
    exp_q.push_back(set_f);
    upd_req = 1'b1;
    cyc();
    upd_req = 1'b0;
    wait_ack0("post_rst", 30);
    chki("sb_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
